// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult
//   Sequential radix-4 Booth multiplier with a start/busy/done handshake.
//   Two multiplier bits are retired per clock. Operands are extended by two
//   bits at load time, so both signed and unsigned products are exact.
//   A multiply takes WIDTH/2+1 RUN cycles.
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        request, sampled only while busy=0
//   is_signed  in   1        1: two's-complement operands, 0: unsigned
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   busy       out  1        multiply in progress
//   done       out  1        one-cycle pulse, product valid and updated
//   product    out  2*WIDTH  result, held until the next completion
module booth_r4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;          // extended operand width
    localparam int BW   = EW + 1;             // multiplier plus implicit b[-1]
    localparam int AW   = 2 * WIDTH + 4;      // accumulator width
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Radix-4 Booth recoding of one triplet into a partial product of m.
    function automatic logic [AW-1:0] booth_pp(input logic [2:0] trip,
                                               input logic [AW-1:0] m);
        case (trip)
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m << 1;
            3'b100:         booth_pp = -(m << 1);
            3'b101, 3'b110: booth_pp = -m;
            default:        booth_pp = {AW{1'b0}};
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [AW-1:0]        a_q, a_d;          // multiplicand, pre-shifted by 2i
    logic [BW-1:0]        b_q, b_d;          // multiplier, triplet sits in [2:0]
    logic [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [AW-1:0]        acc_sum_s;
    logic                 a_ext_s;
    logic                 b_ext_s;

    // Next-state, datapath and output logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        acc_sum_s = acc_q + booth_pp(b_q[2:0], a_q);
        a_ext_s   = is_signed & a[WIDTH-1];
        b_ext_s   = is_signed & b[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Multiplicand is extended all the way to the accumulator
                    // width so partial products never need further extension.
                    a_d     = {{(AW-WIDTH){a_ext_s}}, a};
                    b_d     = {{2{b_ext_s}}, b, 1'b0};
                    acc_d   = {AW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_sum_s;
                a_d   = a_q << 2;
                b_d   = b_q >> 2;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_CNT) begin
                    product_d = acc_sum_s[2*WIDTH-1:0];
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= {AW{1'b0}};
            b_q       <= {BW{1'b0}};
            acc_q     <= {AW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
